// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - sequential ALU: single-cycle logic/arith/shift ops, iterative shift-add multiply
module seq_alu #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             Carry,
    output logic             Negative,
    output logic             Overflow
);

    localparam int SW = $clog2(WIDTH);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_MUL  = 1'b1;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_SRL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    logic [0:0]         state;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [SW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc_next;

    logic [SW-1:0]      shamt;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [WIDTH:0]     shl;
    logic [WIDTH:0]     shr;

    logic [WIDTH-1:0]   alu_r;
    logic               alu_c;
    logic               alu_v;

    logic               wr_en;
    logic [WIDTH-1:0]   wr_r;
    logic               wr_c;
    logic               wr_v;

    assign shamt = B[SW-1:0];
    assign sum   = {1'b0, A} + {1'b0, B};
    // The extra top bit of the difference is the borrow, i.e. A < B unsigned.
    assign diff  = {1'b0, A} - {1'b0, B};
    // One spare bit on each shift catches the last bit shifted out (stays 0 when shamt is 0).
    assign shl   = {1'b0, A} << shamt;
    assign shr   = {A, 1'b0} >> shamt;

    assign acc_next = mplier[0] ? (acc + mcand) : acc;
    assign busy     = (state == S_MUL);

    always_comb begin
        alu_r = '0;
        alu_c = 1'b0;
        alu_v = 1'b0;
        case (op)
            OP_ADD: begin
                alu_r = sum[WIDTH-1:0];
                alu_c = sum[WIDTH];
                alu_v = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                alu_r = diff[WIDTH-1:0];
                alu_c = diff[WIDTH];
                alu_v = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
            end
            OP_AND: alu_r = A & B;
            OP_OR:  alu_r = A | B;
            OP_XOR: alu_r = A ^ B;
            OP_SLL: begin
                alu_r = shl[WIDTH-1:0];
                alu_c = shl[WIDTH];
            end
            OP_SRL: begin
                alu_r = shr[WIDTH:1];
                alu_c = shr[0];
            end
            default: begin
                alu_r = '0;
                alu_c = 1'b0;
            end
        endcase
    end

    // Single write path for Result and flags, shared by the IDLE ops and the last MUL step.
    always_comb begin
        wr_en = 1'b0;
        wr_r  = alu_r;
        wr_c  = alu_c;
        wr_v  = alu_v;
        if (state == S_IDLE) begin
            wr_en = start && (op != OP_MUL);
        end else if (&cnt) begin
            wr_en = 1'b1;
            wr_r  = acc_next[WIDTH-1:0];
            wr_c  = |acc_next[2*WIDTH-1:WIDTH];
            wr_v  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            cnt      <= '0;
            done     <= 1'b0;
            Result   <= '0;
            Zero     <= 1'b0;
            Carry    <= 1'b0;
            Negative <= 1'b0;
            Overflow <= 1'b0;
        end else begin
            done <= wr_en;
            if (wr_en) begin
                Result   <= wr_r;
                Zero     <= (wr_r == '0);
                Carry    <= wr_c;
                Negative <= wr_r[WIDTH-1];
                Overflow <= wr_v;
            end
            case (state)
                S_IDLE: begin
                    if (start && (op == OP_MUL)) begin
                        state  <= S_MUL;
                        acc    <= '0;
                        mcand  <= {{WIDTH{1'b0}}, A};
                        mplier <= B;
                        cnt    <= '0;
                    end
                end
                S_MUL: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (&cnt) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - self-checking bench for seq_alu with a behavioural reference model
module tb_seq_alu;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         zero;
    logic         carry;
    logic         negative;
    logic         overflow;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    seq_alu #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .A        (a_in),
        .B        (b_in),
        .busy     (busy),
        .done     (done),
        .Result   (result),
        .Zero     (zero),
        .Carry    (carry),
        .Negative (negative),
        .Overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic straight from the operation definitions, using integer maths.
    function automatic void calc(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] r, output logic c, output logic v);
        int          sa;
        int          sb;
        int          t;
        int unsigned sh;
        logic [31:0] wide;
        sa = int'($signed(a));
        sb = int'($signed(b));
        sh = int'(b) % W;
        c  = 1'b0;
        v  = 1'b0;
        r  = '0;
        case (o)
            3'd0: begin
                wide = 32'(a) + 32'(b);
                r = wide[W-1:0];
                c = wide[W];
                t = sa + sb;
                v = (t > 32767) || (t < -32768);
            end
            3'd1: begin
                r = a - b;
                c = (a < b);
                t = sa - sb;
                v = (t > 32767) || (t < -32768);
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: begin
                r = a << sh;
                c = (sh == 0) ? 1'b0 : a[W-sh];
            end
            3'd6: begin
                r = a >> sh;
                c = (sh == 0) ? 1'b0 : a[sh-1];
            end
            default: begin
                wide = 32'(a) * 32'(b);
                r = wide[W-1:0];
                c = (wide[31:16] != 16'h0);
            end
        endcase
    endfunction

    logic         m_busy, m_done, m_z, m_c, m_n, m_v;
    logic [W-1:0] m_res;
    int           m_left;
    logic [W-1:0] p_res, c_res;
    logic         p_c, p_v, c_c, c_v;

    always @(posedge clk) begin
        if (reset) begin
            m_busy = 1'b0; m_done = 1'b0; m_left = 0;
            m_res = '0; m_z = 1'b0; m_c = 1'b0; m_n = 1'b0; m_v = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 1'b0; m_done = 1'b1;
                    m_res = p_res; m_c = p_c; m_v = p_v;
                    m_z = (p_res == '0); m_n = p_res[W-1];
                end
            end else if (start) begin
                calc(op, a_in, b_in, c_res, c_c, c_v);
                if (op == 3'd7) begin
                    m_busy = 1'b1; m_left = W;
                    p_res = c_res; p_c = c_c; p_v = c_v;
                end else begin
                    m_done = 1'b1;
                    m_res = c_res; m_c = c_c; m_v = c_v;
                    m_z = (c_res == '0); m_n = c_res[W-1];
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc.done", done, m_done);
            chk("cyc.busy", busy, m_busy);
            chk("cyc.result", result, m_res);
            chk("cyc.zero", zero, m_z);
            chk("cyc.carry", carry, m_c);
            chk("cyc.negative", negative, m_n);
            chk("cyc.overflow", overflow, m_v);
        end
    end

    task automatic do_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        start = 1'b1; op = o; a_in = a; b_in = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic expect_out(input string n, input logic [W-1:0] r, input logic z, input logic c,
                              input logic ng, input logic v);
        chk({n, ".result"}, result, r);
        chk({n, ".zero"}, zero, z);
        chk({n, ".carry"}, carry, c);
        chk({n, ".negative"}, negative, ng);
        chk({n, ".overflow"}, overflow, v);
    endtask

    task automatic wait_done(input string n);
        int k;
        k = 0;
        while (!done && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk({n, ".done_seen"}, done, 1'b1);
    endtask

    logic [2:0]   vop[12] = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd5, 3'd6, 3'd7};
    logic [W-1:0] va[12]  = '{16'hFFFF, 16'h8000, 16'h8000, 16'h1234, 16'hF0F0, 16'hF0F0, 16'hAAAA,
                              16'h1234, 16'h8001, 16'h0001, 16'hFFFF, 16'hFFFF};
    logic [W-1:0] vb[12]  = '{16'h0001, 16'h8000, 16'h0001, 16'h1234, 16'h0FF0, 16'h0F0F, 16'hAAAA,
                              16'h0014, 16'h000F, 16'h000F, 16'h0004, 16'hFFFF};

    initial begin
        int k;
        int busy_cnt;
        int seen;
        reset = 1'b1; start = 1'b0; op = '0; a_in = '0; b_in = '0;
        repeat (2) @(negedge clk);
        chk("reset.busy", busy, 1'b0);
        chk("reset.done", done, 1'b0);
        expect_out("reset", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        cmp_en = 1'b1;
        reset = 1'b0;
        @(negedge clk);

        do_op(3'd0, 16'h7FFF, 16'h0001);
        chk("add.done", done, 1'b1);
        chk("add.busy", busy, 1'b0);
        expect_out("add", 16'h8000, 1'b0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        chk("add.done_pulse", done, 1'b0);

        do_op(3'd1, 16'h0003, 16'h0005);
        expect_out("sub", 16'hFFFE, 1'b0, 1'b1, 1'b1, 1'b0);

        start = 1'b1; op = 3'd5; a_in = 16'h8001; b_in = 16'h0011;
        @(negedge clk);
        chk("b2b.done1", done, 1'b1);
        expect_out("sll", 16'h0002, 1'b0, 1'b1, 1'b0, 1'b0);
        op = 3'd6; a_in = 16'h8001; b_in = 16'h0000;
        @(negedge clk);
        chk("b2b.done2", done, 1'b1);
        expect_out("srl", 16'h8001, 1'b0, 1'b0, 1'b1, 1'b0);
        op = 3'd0; a_in = 16'hFFFF; b_in = 16'h0001;
        @(negedge clk);
        chk("b2b.done3", done, 1'b1);
        expect_out("add_wrap", 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
        start = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            do_op(vop[i], va[i], vb[i]);
            wait_done("vec");
            @(negedge clk);
        end

        do_op(3'd7, 16'h0123, 16'h0010);
        busy_cnt = 0;
        k = 0;
        while (!done && k < 40) begin
            if (busy) busy_cnt++;
            start = (k == 2);
            op = (k == 2) ? 3'd0 : 3'($urandom_range(0, 7));
            a_in = 16'($urandom);
            b_in = 16'($urandom);
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        chk("mul.latency", k, 16);
        chk("mul.busy_cycles", busy_cnt, 16);
        chk("mul.done", done, 1'b1);
        expect_out("mul", 16'h1230, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("mul.done_pulse", done, 1'b0);

        do_op(3'd7, 16'h0100, 16'h0100);
        wait_done("mul2");
        expect_out("mul2", 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);

        do_op(3'd7, 16'h0123, 16'h0010);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort.busy", busy, 1'b0);
        chk("abort.done", done, 1'b0);
        expect_out("abort", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk("abort.no_done", seen, 0);

        reset = 1'b1; start = 1'b1; op = 3'd0; a_in = 16'h0001; b_in = 16'h0001;
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        chk("rst_prio.done", done, 1'b0);
        chk("rst_prio.result", result, 16'h0000);
        @(negedge clk);
        chk("rst_prio.late_done", done, 1'b0);

        do_op(3'd4, 16'h00FF, 16'h0F0F);
        expect_out("xor", 16'h0FF0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter: WIDTH, default 16, operand/result width; SHALL be a power of two, 4..64.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 op  input  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLL, 110 SRL, 111 MUL.
REQ-006 A  input  WIDTH  first operand.
REQ-007 B  input  WIDTH  second operand; low log2(WIDTH) bits give the shift amount for SLL/SRL.
REQ-008 busy  output  1  high while a MUL is in progress.
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 Result  output  WIDTH  registered result; held until the next completion.
REQ-011 Zero, Carry, Negative, Overflow  output  1 each  registered flags, updated only with Result.

Function
REQ-012 The FSM SHALL have two states: IDLE and MUL.
REQ-013 In IDLE, start=1 at edge N SHALL capture op, A and B at edge N.
REQ-014 Ops 000-110: Result and flags SHALL update at edge N; done=1 for exactly the cycle after N; busy stays 0; state stays IDLE.
REQ-015 MUL: edge N SHALL enter MUL with busy=1 and run an iterative shift-add over WIDTH cycles; at edge N+WIDTH Result = low WIDTH bits of the unsigned product, done=1 for one cycle, busy=0, state IDLE.
REQ-016 start SHALL be ignored while busy=1; no queuing.
REQ-017 start in the cycle done=1 (state IDLE) SHALL be accepted, giving back-to-back single-cycle ops every cycle.
REQ-018 A/B/op changes after capture SHALL NOT affect an in-progress MUL.
REQ-019 ADD: Carry = carry-out; Overflow = signed overflow.
REQ-020 SUB: Result = A-B mod 2^WIDTH; Carry = 1 iff A<B unsigned (borrow); Overflow = signed overflow.
REQ-021 AND/OR/XOR: Carry=0, Overflow=0.
REQ-022 SLL/SRL: shift amount s = B mod WIDTH; zero fill; Carry = last bit shifted out (0 when s=0); Overflow=0.
REQ-023 MUL: Carry = 1 iff the upper WIDTH bits of the full product are nonzero; Overflow=0.
REQ-024 All ops: Zero = (Result==0); Negative = Result[WIDTH-1].
REQ-025 Unused op encodings: none; all 8 are defined.

Reset
REQ-026 reset=1 at an edge SHALL force IDLE, busy=0, done=0, Result=0, all four flags=0 (Zero=0 despite Result=0), and clear the MUL iteration state.
REQ-027 reset SHALL take priority over start in the same cycle.
REQ-028 reset during MUL SHALL abort it; no done pulse for the aborted operation.

Verification (WIDTH=16)
REQ-029 ADD A=0x7FFF B=0x0001 -> Result 0x8000, Overflow 1, Negative 1, Carry 0, Zero 0; done for 1 cycle after start edge.
REQ-030 SUB A=0x0003 B=0x0005 -> Result 0xFFFE, Carry 1, Negative 1, Overflow 0.
REQ-031 MUL A=0x0123 B=0x0010 -> busy high 16 cycles, done at edge N+16, Result 0x1230, Carry 0; a start pulse at cycle N+3 is ignored.
REQ-032 MUL A=0x0100 B=0x0100 -> Result 0x0000, Zero 1, Carry 1.
REQ-033 SLL A=0x8001 B=0x0011 (s=1) -> Result 0x0002, Carry 1; SRL A=0x8001 B=0x0000 -> Result 0x8001, Carry 0.
REQ-034 reset asserted for 1 cycle at N+5 of a MUL -> next edge busy 0, done 0, Result 0x0000, flags 0; no later done until a new start.
